// File: rtl/inverse_dct4x4.sv
// 4x4 inverse DCT on IEEE-754 single-precision coefficients: latches one block and
// streams 16 reconstructed pixels through a pipelined multiply / adder-tree datapath.

module fp_delay #(
    parameter int W     = 32,
    parameter int DEPTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] in_d,
    output logic [W-1:0] out_q
);
    logic [W-1:0] pipe_q [DEPTH];
    logic [W-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = in_d;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else if (ce) begin
            pipe_q <= pipe_d;
        end
    end

    assign out_q = pipe_q[DEPTH-1];
endmodule

module fp_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r
);
    // Denormals flush to zero; round to nearest even.
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        logic [47:0] prod;
        logic [24:0] mant;
        logic        g;
        logic        st;
        int          e;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
        if (x[30:23] == 8'hff || y[30:23] == 8'hff) return {s, 8'hff, 23'd0};
        prod = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e    = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (prod[47]) begin
            mant = {1'b0, prod[47:24]};
            g    = prod[23];
            st   = |prod[22:0];
            e    = e + 1;
        end else begin
            mant = {1'b0, prod[46:23]};
            g    = prod[22];
            st   = |prod[21:0];
        end
        if (g && (st || mant[0])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e <= 0) return {s, 31'd0};
        if (e >= 255) return {s, 8'hff, 23'd0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    logic [31:0] res_s;
    assign res_s = fmul(a, b);

    fp_delay #(.W(32), .DEPTH(5)) u_pipe (.clk(clk), .rst(rst), .ce(ce), .in_d(res_s), .out_q(r));
endmodule

module fp_add (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r
);
    // Guard/round/sticky alignment, round to nearest even, exact cancellation gives +0.
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] hi;
        logic [31:0] lo;
        logic [26:0] ma;
        logic [26:0] mb;
        logic [26:0] mbs;
        logic [27:0] sum;
        logic [24:0] mant;
        logic        sticky;
        logic        found;
        int          e;
        int          d;
        int          lz;
        sticky = 1'b0;
        if (x[30:23] == 8'd0 && y[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
        if (x[30:23] == 8'd0) return y;
        if (y[30:23] == 8'd0) return x;
        if (x[30:23] == 8'hff) return x;
        if (y[30:23] == 8'hff) return y;
        if (x[30:0] >= y[30:0]) begin
            hi = x;
            lo = y;
        end else begin
            hi = y;
            lo = x;
        end
        ma = {1'b1, hi[22:0], 3'd0};
        mb = {1'b1, lo[22:0], 3'd0};
        d  = int'(hi[30:23]) - int'(lo[30:23]);
        if (d > 26) begin
            mbs = {26'd0, 1'b1};
        end else begin
            for (int i = 0; i < 27; i++) if (i < d && mb[i]) sticky = 1'b1;
            mbs = (mb >> d) | {26'd0, sticky};
        end
        if (hi[31] == lo[31]) sum = {1'b0, ma} + {1'b0, mbs};
        else                  sum = {1'b0, ma} - {1'b0, mbs};
        if (sum == 28'd0) return 32'd0;
        e = int'(hi[30:23]);
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 1;
        end else begin
            lz    = 0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (sum[i]) found = 1'b1;
                    else        lz = lz + 1;
                end
            end
            sum = sum << lz;
            e   = e - lz;
        end
        mant = {1'b0, sum[26:3]};
        if (sum[2] && ((sum[1] | sum[0]) || mant[0])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e <= 0) return {hi[31], 31'd0};
        if (e >= 255) return {hi[31], 8'hff, 23'd0};
        return {hi[31], e[7:0], mant[22:0]};
    endfunction

    logic [31:0] res_s;
    assign res_s = fadd(a, b);

    fp_delay #(.W(32), .DEPTH(7)) u_pipe (.clk(clk), .rst(rst), .ce(ce), .in_d(res_s), .out_q(r));
endmodule

module inverse_dct4x4 (
    input  logic         Reset,
    input  logic         CLK,
    input  logic         CE,
    input  logic         start,
    input  logic [255:0] D1_i,
    input  logic [255:0] D2_i,
    output logic         busy,
    output logic [31:0]  data_o,
    output logic         valid_o,
    output logic [1:0]   nx_o,
    output logic [1:0]   ny_o,
    output logic         done
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;
    localparam int TRK_DEPTH = 38;

    state_t      state_q, state_d;
    logic [3:0]  p_q, p_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] coef_q [16];
    logic [31:0] coef_d [16];
    logic [4:0]  trk_q [TRK_DEPTH];
    logic [4:0]  trk_d [TRK_DEPTH];

    // C[n][i] basis table, indexed by pixel coordinate n and frequency i.
    function automatic logic [31:0] cos_tab(input logic [1:0] n, input logic [1:0] i);
        logic [31:0] c;
        case ({i, n})
            4'b0000, 4'b0001, 4'b0010, 4'b0011: c = 32'h3f000000;
            4'b0100: c = 32'h3f273d74;
            4'b0101: c = 32'h3e8a8bd4;
            4'b0110: c = 32'hbe8a8bd4;
            4'b0111: c = 32'hbf273d74;
            4'b1000, 4'b1011: c = 32'h3f000000;
            4'b1001, 4'b1010: c = 32'hbf000000;
            4'b1100: c = 32'h3e8a8bd4;
            4'b1101: c = 32'hbf273d74;
            4'b1110: c = 32'h3f273d74;
            4'b1111: c = 32'hbe8a8bd4;
            default: c = 32'h00000000;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        busy_d  = busy_q;
        coef_d  = coef_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    p_d     = 4'd0;
                    busy_d  = 1'b1;
                    for (int j = 0; j < 8; j++) begin
                        coef_d[j]   = D1_i[255 - 32*j -: 32];
                        coef_d[j+8] = D2_i[255 - 32*j -: 32];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                p_d = p_q + 4'd1;
                if (p_q == 4'd15) state_d = S_DRAIN;
                else              state_d = S_ISSUE;
            end
            S_DRAIN: begin
                // Leave once the last pixel is on the output.
                if (done_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            p_q     <= 4'd0;
            busy_q  <= 1'b0;
            for (int j = 0; j < 16; j++) coef_q[j] <= 32'd0;
        end else if (CE) begin
            state_q <= state_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            coef_q  <= coef_d;
        end
    end

    // Tracker depth matches datapath latency: 5 + 5 + 4*7.
    always_comb begin
        trk_d[0] = {state_q == S_ISSUE, p_q};
        for (int i = 1; i < TRK_DEPTH; i++) trk_d[i] = trk_q[i-1];
        done_d = trk_q[TRK_DEPTH-2][4] & (trk_q[TRK_DEPTH-2][3:0] == 4'd15);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < TRK_DEPTH; i++) trk_q[i] <= 5'd0;
            done_q <= 1'b0;
        end else if (CE) begin
            trk_q  <= trk_d;
            done_q <= done_d;
        end
    end

    logic [31:0] wa_s [16];
    logic [31:0] wb_s [16];
    logic [31:0] w_s [16];
    logic [31:0] prod_s [16];
    logic [31:0] l1_s [8];
    logic [31:0] l2_s [4];
    logic [31:0] l3_s [2];

    for (genvar k = 0; k < 16; k++) begin : g_mul
        assign wa_s[k] = cos_tab(p_q[1:0], 2'(k % 4));
        assign wb_s[k] = cos_tab(p_q[3:2], 2'(k / 4));
        fp_mult u_wmul (.clk(CLK), .rst(Reset), .ce(CE), .a(wa_s[k]), .b(wb_s[k]), .r(w_s[k]));
        fp_mult u_dmul (.clk(CLK), .rst(Reset), .ce(CE), .a(coef_q[k]), .b(w_s[k]), .r(prod_s[k]));
    end

    for (genvar k = 0; k < 8; k++) begin : g_add1
        fp_add u_add (.clk(CLK), .rst(Reset), .ce(CE), .a(prod_s[2*k]), .b(prod_s[2*k+1]), .r(l1_s[k]));
    end
    for (genvar k = 0; k < 4; k++) begin : g_add2
        fp_add u_add (.clk(CLK), .rst(Reset), .ce(CE), .a(l1_s[2*k]), .b(l1_s[2*k+1]), .r(l2_s[k]));
    end
    for (genvar k = 0; k < 2; k++) begin : g_add3
        fp_add u_add (.clk(CLK), .rst(Reset), .ce(CE), .a(l2_s[2*k]), .b(l2_s[2*k+1]), .r(l3_s[k]));
    end
    fp_add u_add4 (.clk(CLK), .rst(Reset), .ce(CE), .a(l3_s[0]), .b(l3_s[1]), .r(data_o));

    assign busy    = busy_q;
    assign done    = done_q;
    assign valid_o = trk_q[TRK_DEPTH-1][4];
    assign ny_o    = trk_q[TRK_DEPTH-1][3:2];
    assign nx_o    = trk_q[TRK_DEPTH-1][1:0];
endmodule

// File: doc/inverse_dct4x4.md
# inverse_dct4x4

Reconstructs one 4x4 block of single-precision float pixels from the 16 float DCT coefficients produced by the forward CalculateMatrix accumulator. It is the read-side counterpart of the forward transform. It latches the two 256-bit coefficient words from coefficient RAM, then streams 16 pixels in raster order through a fully pipelined multiply/adder-tree datapath built from the FpMult (5 clk) and FpAdd (7 clk) primitives. It sits between coefficient RAM and the pixel output/readback path.

## Interface
- No parameters. Datapath is fixed at 4x4 and IEEE-754 single precision.
- Reset  in  1  asynchronous, active-high; clears all state and drives `aclr` of every FP primitive.
- CLK  in  1  single clock.
- CE  in  1  clock enable; when low, all state, including FP primitives, holds.
- start  in  1  request to transform the block currently on D1_i/D2_i.
- D1_i  in  256  coefficients D[0..7]; D[0] = bits 255:224, D[7] = bits 31:0.
- D2_i  in  256  coefficients D[8..15], same packing.
- busy  out  1  block in progress; start is ignored while high.
- data_o  out  32  reconstructed pixel, float.
- valid_o  out  1  data_o, nx_o and ny_o are valid this cycle.
- nx_o  out  2  column of the current pixel.
- ny_o  out  2  row of the current pixel.
- done  out  1  one-cycle pulse, coincident with the last pixel.

## Operation
- Coefficient index k: u = k%4 pairs with nx, v = k/4 pairs with ny.
- Pixel equation: f(nx,ny) = sum over k of D[k] * C[nx][k%4] * C[ny][k/4].
- C[n][i] = Q(i)*cos(pi/4*(n+0.5)*i), with Q(0) = 1/2 and Q(i≠0) = 1/sqrt2. Constants:
  - Column i=0: 3f000000 (0.5) for every n.
  - Column i=1: 3f273d74, 3e8a8bd4, be8a8bd4, bf273d74.
  - Column i=2: 3f000000, bf000000, bf000000, 3f000000.
  - Column i=3: 3e8a8bd4, bf273d74, 3f273d74, be8a8bd4.
- Accept rule: start=1, busy=0, CE=1 at a clock edge → D1_i/D2_i latched into a 16x32 coefficient register, and busy=1 from the next cycle. The coefficient register is stable for the whole block.
- FSM:
  - IDLE → ISSUE on accept.
  - ISSUE: 4-bit pixel counter p runs 0..15, one per CE cycle, with nx = p%4 and ny = p/4. After p=15 issues → DRAIN.
  - DRAIN: waits until the tracker reports p=15 at output → IDLE.
- Datapath per issued pixel:
  - 16 weight multipliers: C[nx][k%4] × C[ny][k/4].
  - 16 data multipliers: latched D[k] × weight[k].
  - 4-level FpAdd tree: 8+4+2+1 adders reduce to data_o.
- Tracker: 38-deep shift register of {valid, p}, advanced only on CE. Its output drives valid_o, nx_o and ny_o.
- done = valid_o & (p_out = 15). busy falls in the cycle after done.
- start while busy: ignored, with no effect on the latched coefficients.
- Reset mid-block:
  - FSM → IDLE, tracker cleared, coefficient register zeroed.
  - No valid_o or done is produced for the aborted block.
  - A new start is accepted the first CE cycle after reset is released.

## Timing
- Reset values: busy=0, valid_o=0, done=0, nx_o=0, ny_o=0, data_o=0.
- Accept edge = cycle 0. Pixel p issues in CE cycle 1+p.
- Pixel p appears on valid_o in CE cycle 39+p: 5 (weight) + 5 (data mult) + 28 (4×7 adders).
- Pixels come out contiguously in raster order (0,0),(1,0),…,(3,3), one per CE cycle, over CE cycles 39..54.
- done is high in CE cycle 54. busy is high in cycles 1..54 and low from 55.
- Earliest next accept is cycle 55, giving a throughput of 1 block per 55 CE cycles.
- CE=0 cycles stretch all counts with no loss. valid_o is meaningful only when CE=1.

## Test plan
- D[0]=3f800000 (1.0), all others 0 → 16 pixels, each 3e800000 (0.25). First valid_o at cycle 39, done at cycle 54.
- D[2]=3f800000, others 0 → pixels are +0.25 for nx∈{0,3} and −0.25 (be800000) for nx∈{1,2}, on every row. nx_o and ny_o are in raster order.
- Round trip: random 4x4 pixel block → forward CalculateMatrix → inverse_dct4x4 → matches the original within 1e-5 relative.
- Assert start every cycle, with D1_i/D2_i changing during busy → output matches the first latched block only, and the next accept is at cycle 55.
- CE toggled pseudo-randomly at 50% → identical pixel sequence, with count = 55 CE-high cycles.
- Reset asserted at cycle 20 → busy, valid_o and done are 0 immediately, with no stray valid_o afterwards. A restart yields correct output.
